spi_master_param: RTL and testbench
===================================

Name: spi_master_param

Overview:
Parametrised successor to the fixed-format SPI transmit FSM. Full-duplex SPI master with configurable word width, SCLK divider, bit order and all four CPOL/CPHA modes.
- Adds a MISO receive path and a ready/valid style handshake.
- Sits between on-chip control logic and a single off-chip SPI slave.

Parameters:
DATA_W, 8, bits per transfer (>=2)
CLK_DIV, 4, clk cycles per SCLK half-period (>=2)
CPOL, 0, SCLK idle level
CPHA, 0, 0 = sample on leading edge / shift on trailing edge; 1 = shift on leading edge / sample on trailing edge
MSB_FIRST, 1, 1 = bit DATA_W-1 first; 0 = bit 0 first

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous, active-high reset
tx_enable  input  1  start request; accepted only when tx_ready=1
tx_data  input  DATA_W  word to send; latched on accept edge
tx_ready  output  1  high in IDLE, i.e. a request can be accepted
busy  output  1  high from accept until return to IDLE
rx_data  output  DATA_W  received word; valid while rx_valid=1 and held until the next completion
rx_valid  output  1  one-cycle pulse at transfer completion
miso  input  1  serial data from slave
mosi  output  1  serial data to slave
cs  output  1  active-low chip select
sclk  output  1  serial clock

Behaviour:
- Reset values: cs=1, sclk=CPOL, mosi=0, tx_ready=1, busy=0, rx_valid=0, rx_data=0. Divider, bit counter and state are cleared.
- States: IDLE, SETUP, XFER, HOLD, GAP.
- Accept: posedge with state=IDLE and tx_enable=1 latches tx_data.
  - cs goes low the next cycle.
  - tx_ready=0 and busy=1 from the next cycle.
- IDLE -> SETUP on accept.
  - SETUP lasts CLK_DIV cycles.
  - CPHA=0: mosi presents the first bit from cs falling.
- SETUP -> XFER.
  - XFER has 2*DATA_W half-periods of CLK_DIV cycles each.
  - sclk toggles at the end of each half-period.
  - Leading edges are the odd toggles; trailing edges are the even toggles.
- Sample edge: miso is shifted into the rx shift register on the same clk edge that sclk toggles.
- Shift edge: mosi updates to the next bit on the same clk edge that sclk toggles.
  - CPHA=1: the first bit appears on the first leading edge.
  - CPHA=0: no shift after the last trailing edge.
- XFER -> HOLD after the 2*DATA_W-th toggle. sclk is now back at CPOL. HOLD lasts CLK_DIV cycles with cs still low.
- HOLD -> GAP:
  - cs=1, mosi=0.
  - rx_data updated and rx_valid=1 for exactly 1 cycle.
  - GAP lasts CLK_DIV cycles, which is the minimum cs-high time.
- GAP -> IDLE: tx_ready=1, busy=0.
- Latency: rx_valid is high exactly (2*DATA_W+2)*CLK_DIV+1 clk cycles after the accept edge.
- Bit order: MSB_FIRST selects both the transmit order and the receive assembly, so that loopback returns tx_data unchanged.
- tx_enable and tx_data are ignored while busy. tx_data may change after the accept edge without affecting the transfer.
- tx_enable held high gives back-to-back transfers, each separated by the GAP.
- rst mid-transfer: on the next posedge all outputs return to their reset values. No rx_valid is produced and the partial word is discarded.
- rst has priority over an accept in the same cycle.

Decomposition:
- Package spi_pkg holds:
  - state enum spi_state_t (IDLE, SETUP, XFER, HOLD, GAP)
  - mode constants SPI_MODE0..3 encoding {CPOL,CPHA}
  - function clog2 for counter widths
- Sub-module spi_clk_gen (parameter CLK_DIV):
  - Inputs: clk, rst, enable.
  - Output: a one-cycle tick every CLK_DIV cycles while enabled.
  - The counter clears when enable is low.
  - Used by all timed states.

Test Plan:
- Mode 0, DATA_W=8, CLK_DIV=4, miso tied to mosi, tx_data=0xA5:
  - exactly 16 sclk toggles
  - mosi on the leading edges reads 1,0,1,0,0,1,0,1
  - rx_data=0xA5 with rx_valid 73 cycles after accept
- Mode 3 (CPOL=1, CPHA=1), slave model returns 0x3C, tx 0xF0:
  - sclk idles high
  - rx_data=0x3C
  - the slave model captures 0xF0 on rising edges
- MSB_FIRST=0, DATA_W=16, tx 0x8001, loopback:
  - first mosi bit = 1 (bit 0), last = 1
  - rx_data=0x8001
- tx_enable held high, tx_data=0x11 then 0x22:
  - two transfers
  - cs high for >= CLK_DIV cycles between them
  - rx_valid pulses twice, each for 1 cycle
- tx_enable pulsed mid-XFER with new data 0xFF:
  - ignored; the original word completes
  - only one rx_valid
- rst asserted for 1 cycle at the 5th sclk toggle:
  - next cycle cs=1, sclk=CPOL, busy=0, tx_ready=1
  - no rx_valid
  - a subsequent 0x5A loopback transfer completes correctly

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and helpers for the parametrised SPI master.
// Mode constants encode {CPOL,CPHA}.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        GAP
    } spi_state_t;

    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((32'sd1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timer: one-cycle tick every CLK_DIV cycles while enabled.
// Counter is held at zero whenever enable is low.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int CW = (clog2(CLK_DIV) < 1) ? 1 : clog2(CLK_DIV);

    logic [CW-1:0] cnt;

    assign tick = enable && (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || !enable) cnt <= '0;
        else if (tick) cnt <= '0;
        else cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/spi_master_param.sv
// Full-duplex SPI master: configurable width, divider, bit order, CPOL/CPHA.
// Every timed state advances on the shared half-period tick.
module spi_master_param
    import spi_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 4,
    parameter int CPOL      = 0,
    parameter int CPHA      = 0,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_enable,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              busy,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              miso,
    output logic              mosi,
    output logic              cs,
    output logic              sclk
);

    localparam int HW = clog2(2 * DATA_W);
    localparam logic [1:0] MODE = {CPOL != 0, CPHA != 0};
    localparam logic SAMPLE_LEAD = (MODE == SPI_MODE0) || (MODE == SPI_MODE2);
    localparam logic IDLE_LVL = (CPOL != 0);
    localparam logic [HW-1:0] LAST = HW'(2 * DATA_W - 1);

    spi_state_t        state;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic [HW-1:0]     hcnt;
    logic              tick;
    logic              lead;
    logic              last_tog;

    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
    endfunction

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w,
                                                    input logic b);
        return (MSB_FIRST != 0) ? {w[DATA_W-2:0], b} : {b, w[DATA_W-1:1]};
    endfunction

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk   (clk),
        .rst   (rst),
        .enable(state != IDLE),
        .tick  (tick)
    );

    // hcnt counts completed toggles; even count means the next one is leading
    assign lead     = ~hcnt[0];
    assign last_tog = (hcnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cs       <= 1'b1;
            sclk     <= IDLE_LVL;
            mosi     <= 1'b0;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            hcnt     <= '0;
        end else begin
            rx_valid <= 1'b0;
            unique case (state)
                IDLE: if (tx_enable) begin
                    state    <= SETUP;
                    cs       <= 1'b0;
                    tx_ready <= 1'b0;
                    busy     <= 1'b1;
                    rx_sr    <= '0;
                    hcnt     <= '0;
                    if (SAMPLE_LEAD) begin
                        mosi  <= first_bit(tx_data);
                        tx_sr <= shift_out(tx_data);
                    end else begin
                        tx_sr <= tx_data;
                    end
                end
                SETUP: if (tick) state <= XFER;
                XFER: if (tick) begin
                    sclk <= ~sclk;
                    hcnt <= hcnt + 1'b1;
                    if (lead == SAMPLE_LEAD)
                        rx_sr <= shift_in(rx_sr, miso);
                    // CPHA=0 has already presented its last bit, so skip the final shift
                    if (lead != SAMPLE_LEAD && !(SAMPLE_LEAD && last_tog)) begin
                        mosi  <= first_bit(tx_sr);
                        tx_sr <= shift_out(tx_sr);
                    end
                    if (last_tog) begin
                        state <= HOLD;
                        hcnt  <= '0;
                    end
                end
                HOLD: if (tick) begin
                    state    <= GAP;
                    cs       <= 1'b1;
                    mosi     <= 1'b0;
                    rx_data  <= rx_sr;
                    rx_valid <= 1'b1;
                end
                GAP: if (tick) begin
                    state    <= IDLE;
                    tx_ready <= 1'b1;
                    busy     <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_param.sv
// Scoreboarded bench for spi_master_param across three configurations.
// A timeline model predicts every output each cycle; words go through a queue.
module tb_spi_master_param;

    localparam int W0 = 8,  D0 = 4, P0 = 0, H0 = 0, M0 = 1;
    localparam int W1 = 8,  D1 = 3, P1 = 1, H1 = 1, M1 = 1;
    localparam int W2 = 16, D2 = 2, P2 = 1, H2 = 0, M2 = 0;

    localparam int WA [3] = '{W0, W1, W2};
    localparam int DA [3] = '{D0, D1, D2};
    localparam int PA [3] = '{P0, P1, P2};
    localparam int HA [3] = '{H0, H1, H2};
    localparam int MA [3] = '{M0, M1, M2};
    localparam int LB [3] = '{1, 0, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  tx_en;
    logic [15:0] tx_d [3];

    logic rdy_0, rdy_1, rdy_2, bsy_0, bsy_1, bsy_2;
    logic rv_0, rv_1, rv_2, mo_0, mo_1, mo_2;
    logic cs_0, cs_1, cs_2, sck_0, sck_1, sck_2;
    logic [7:0]  rx_0, rx_1;
    logic [15:0] rx_2;
    logic        s_miso;

    logic [2:0] rdy, bsy, rv, mo, csn, sck;
    assign rdy = {rdy_2, rdy_1, rdy_0};
    assign bsy = {bsy_2, bsy_1, bsy_0};
    assign rv  = {rv_2, rv_1, rv_0};
    assign mo  = {mo_2, mo_1, mo_0};
    assign csn = {cs_2, cs_1, cs_0};
    assign sck = {sck_2, sck_1, sck_0};

    spi_master_param #(.DATA_W(W0), .CLK_DIV(D0), .CPOL(P0), .CPHA(H0), .MSB_FIRST(M0)) u0 (
        .clk(clk), .rst(rst), .tx_enable(tx_en[0]), .tx_data(tx_d[0][7:0]),
        .tx_ready(rdy_0), .busy(bsy_0), .rx_data(rx_0), .rx_valid(rv_0),
        .miso(mo_0), .mosi(mo_0), .cs(cs_0), .sclk(sck_0));

    spi_master_param #(.DATA_W(W1), .CLK_DIV(D1), .CPOL(P1), .CPHA(H1), .MSB_FIRST(M1)) u1 (
        .clk(clk), .rst(rst), .tx_enable(tx_en[1]), .tx_data(tx_d[1][7:0]),
        .tx_ready(rdy_1), .busy(bsy_1), .rx_data(rx_1), .rx_valid(rv_1),
        .miso(s_miso), .mosi(mo_1), .cs(cs_1), .sclk(sck_1));

    spi_master_param #(.DATA_W(W2), .CLK_DIV(D2), .CPOL(P2), .CPHA(H2), .MSB_FIRST(M2)) u2 (
        .clk(clk), .rst(rst), .tx_enable(tx_en[2]), .tx_data(tx_d[2]),
        .tx_ready(rdy_2), .busy(bsy_2), .rx_data(rx_2), .rx_valid(rv_2),
        .miso(mo_2), .mosi(mo_2), .cs(cs_2), .sclk(sck_2));

    typedef struct {
        int          inst;
        logic [15:0] data;
        int          a;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc;
    int          acc_a [3];
    int          acc_cnt [3];
    logic [15:0] acc_d [3];
    logic [15:0] exp_w [3];
    logic [15:0] last_rx [3];
    logic [15:0] slv_word;
    logic        chk_en;

    task automatic chk(input string nm, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d cyc%0d got %0h want %0h", nm, i, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] mask(input int i);
        return (WA[i] == 16) ? 16'hFFFF : 16'h00FF;
    endfunction

    function automatic logic [15:0] get_rx(input int i);
        case (i)
            0: return {8'h00, rx_0};
            1: return {8'h00, rx_1};
            default: return rx_2;
        endcase
    endfunction

    function automatic int tog(input int i, input int r);
        int t;
        t = r / DA[i] - 1;
        if (t < 0) t = 0;
        if (t > 2 * WA[i]) t = 2 * WA[i];
        return t;
    endfunction

    function automatic logic exp_mosi(input int i, input int r);
        int t, j;
        if (r >= (2 * WA[i] + 2) * DA[i]) return 1'b0;
        t = tog(i, r);
        if (HA[i] == 0) j = (t / 2 < WA[i] - 1) ? t / 2 : WA[i] - 1;
        else if (t == 0) return 1'b0;
        else j = (t - 1) / 2;
        return (MA[i] != 0) ? acc_d[i][WA[i]-1-j] : acc_d[i][j];
    endfunction

    function automatic logic idle_at(input int i, input int c);
        return (c - acc_a[i]) > (2 * WA[i] + 3) * DA[i];
    endfunction

    // reference timeline: decides acceptance and pushes expected words
    initial begin
        cyc = 0;
        for (int i = 0; i < 3; i++) begin
            acc_a[i] = -1000000;
            acc_cnt[i] = 0;
            acc_d[i] = '0;
            exp_w[i] = '0;
            last_rx[i] = '0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                for (int i = 0; i < 3; i++) begin
                    acc_a[i] = -1000000;
                    last_rx[i] = '0;
                end
                q.delete();
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (cyc - acc_a[i] == (2 * WA[i] + 2) * DA[i]) last_rx[i] = exp_w[i];
                    if (tx_en[i] && idle_at(i, cyc)) begin
                        acc_a[i] = cyc;
                        acc_d[i] = tx_d[i] & mask(i);
                        exp_w[i] = (LB[i] != 0) ? acc_d[i] : (slv_word & mask(i));
                        acc_cnt[i]++;
                        q.push_back('{i, exp_w[i], cyc});
                    end
                end
            end
        end
    end

    // monitor: per-cycle pin checks plus scoreboard pop on rx_valid
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int i = 0; i < 3; i++) begin
                    int r, t, n;
                    exp_t e;
                    r = cyc - acc_a[i];
                    t = tog(i, r);
                    n = 2 * WA[i] + 2;
                    chk("cs", i, 32'(csn[i]), 32'(r >= n * DA[i]));
                    chk("busy", i, 32'(bsy[i]), 32'(r < (n + 1) * DA[i]));
                    chk("tx_ready", i, 32'(rdy[i]), 32'(r >= (n + 1) * DA[i]));
                    chk("sclk", i, 32'(sck[i]), 32'((PA[i] != 0) ^ t[0]));
                    chk("mosi", i, 32'(mo[i]), 32'(exp_mosi(i, r)));
                    chk("rx_valid", i, 32'(rv[i]), 32'(r == n * DA[i]));
                    chk("rx_hold", i, 32'(get_rx(i)), 32'(last_rx[i]));
                    if (rv[i]) begin
                        if (q.size() == 0) begin
                            chk("rx_unexpected", i, 32'(get_rx(i)), 32'hFFFF_FFFF);
                        end else begin
                            e = q.pop_front();
                            chk("sb_inst", i, 32'(i), 32'(e.inst));
                            chk("sb_data", i, 32'(get_rx(i)), 32'(e.data));
                            chk("latency", i, 32'(cyc - e.a + 1), 32'(n * DA[i] + 1));
                        end
                    end
                end
            end
        end
    end

    // slave for instance 1: drives slv_word, captures mosi
    initial begin
        int          s_e, s_i, s_c;
        logic        s_pcs, s_psck;
        logic [15:0] s_cap, s_word;
        s_miso = 1'b0;
        s_pcs = 1'b1;
        s_psck = (P1 != 0);
        s_e = 0; s_i = 0; s_c = 0;
        s_cap = '0; s_word = '0;
        forever begin
            @(negedge clk);
            if (chk_en && cs_1 && !s_pcs)
                chk("slave_cap", 1, 32'(s_cap), 32'(acc_d[1]));
            if (!cs_1 && s_pcs) begin
                s_e = 0; s_i = 0; s_c = 0;
                s_cap = '0;
                s_word = slv_word;
                if (H1 == 0) s_miso = (M1 != 0) ? s_word[W1-1] : s_word[0];
            end else if (!cs_1 && sck_1 != s_psck) begin
                s_e++;
                if ((s_e % 2 == 1) == (H1 == 0)) begin
                    if (M1 != 0) s_cap[W1-1-s_c] = mo_1;
                    else s_cap[s_c] = mo_1;
                    s_c++;
                end else begin
                    if (H1 == 0) s_i++;
                    if (s_i < W1) s_miso = (M1 != 0) ? s_word[W1-1-s_i] : s_word[s_i];
                    if (H1 != 0) s_i++;
                end
            end
            s_pcs = cs_1;
            s_psck = sck_1;
        end
    end

    task automatic wait_idle(input int i);
        for (int k = 0; k < 2000; k++) begin
            if (idle_at(i, cyc + 1)) return;
            @(negedge clk);
        end
        chk("idle_timeout", i, 32'd0, 32'd1);
    endtask

    task automatic wait_acc(input int i, input int n0);
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (acc_cnt[i] != n0) return;
        end
        chk("accept_timeout", i, 32'd0, 32'd1);
    endtask

    task automatic send(input int i, input logic [15:0] d);
        int n0;
        wait_idle(i);
        n0 = acc_cnt[i];
        tx_en[i] = 1'b1;
        tx_d[i] = d;
        wait_acc(i, n0);
        tx_en[i] = 1'b0;
        tx_d[i] = 16'($urandom);
        wait_idle(i);
    endtask

    initial begin
        int n0, i;
        logic [15:0] d;
        rst = 1'b1;
        tx_en = '0;
        for (int k = 0; k < 3; k++) tx_d[k] = '0;
        slv_word = '0;
        chk_en = 1'b0;
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        send(0, 16'h00A5);
        slv_word = 16'h003C;
        send(1, 16'h00F0);
        send(2, 16'h8001);

        // back-to-back with tx_enable held high
        wait_idle(0);
        n0 = acc_cnt[0];
        tx_en[0] = 1'b1;
        tx_d[0] = 16'h0011;
        wait_acc(0, n0);
        tx_d[0] = 16'h0022;
        wait_acc(0, n0 + 1);
        tx_en[0] = 1'b0;
        wait_idle(0);

        // request while busy must be ignored
        n0 = acc_cnt[0];
        tx_en[0] = 1'b1;
        tx_d[0] = 16'h0096;
        wait_acc(0, n0);
        tx_en[0] = 1'b0;
        repeat (20) @(negedge clk);
        tx_en[0] = 1'b1;
        tx_d[0] = 16'h00FF;
        @(negedge clk);
        tx_en[0] = 1'b0;
        wait_idle(0);

        // reset at the 5th sclk toggle
        n0 = acc_cnt[0];
        tx_en[0] = 1'b1;
        tx_d[0] = 16'h00C3;
        wait_acc(0, n0);
        tx_en[0] = 1'b0;
        for (int k = 0; k < 200 && (cyc - acc_a[0]) < 6 * D0; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send(0, 16'h005A);

        for (int k = 0; k < 12; k++) begin
            i = int'($urandom_range(0, 2));
            d = 16'($urandom) & mask(i);
            if (i == 1) slv_word = 16'($urandom) & mask(1);
            send(i, d);
        end

        for (int k = 0; k < 500 && q.size() != 0; k++) @(negedge clk);
        chk("queue_drained", 0, 32'(q.size()), 32'd0);
        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
